// File: rtl/ahb_arbiter_mport.sv
// ahb_arbiter_mport: output-stage arbiter for one shared slave port of the L1 AHB bus matrix.
//
// Chooses which of NUM_PORTS input ports drives the next address phase on the shared slave.
// It holds the grant for locked transfers, for defined-length bursts (tracked by a 4-bit beat
// counter) and for undefined-length INCR bursts. Otherwise it re-arbitrates with fixed
// lowest-index priority, or with round-robin priority when ARB_ROUND_ROBIN_EN is defined.
//
// Parameters:
//   NUM_PORTS  number of requesting input ports (2..16)
//   PORT_W     width of addr_in_port, 2**PORT_W >= NUM_PORTS, minimum 1
//
// Ports:
//   HCLK          clock
//   HRESET        synchronous, active-high reset (wins over HREADYM)
//   req_port      per-port request, bit i = input port i
//   HREADYM       shared slave ready; state only advances while high
//   HSELM         slave select of the address phase currently driven
//   HTRANSM       transfer type of the current address phase
//   HBURSTM       burst type of the current address phase
//   HMASTLOCKM    locked transfer, freezes arbitration
//   addr_in_port  registered select for the output-stage address mux
//   no_port       registered "no port selected"
//   burst_hold    registered, high while a defined-length burst locks arbitration
//
// Build option:
//   ARB_ROUND_ROBIN_EN  when defined, a rule-4 grant searches from the port after the last
//                       winner instead of from port 0.

module ahb_arbiter_mport #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned PORT_W    = 2
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic [NUM_PORTS-1:0] req_port,
  input  logic                 HREADYM,
  input  logic                 HSELM,
  input  logic [1:0]           HTRANSM,
  input  logic [2:0]           HBURSTM,
  input  logic                 HMASTLOCKM,
  output logic [PORT_W-1:0]    addr_in_port,
  output logic                 no_port,
  output logic                 burst_hold
);

  localparam logic [1:0] TransIdle   = 2'b00;
  localparam logic [1:0] TransBusy   = 2'b01;
  localparam logic [1:0] TransNonseq = 2'b10;
  localparam logic [1:0] TransSeq    = 2'b11;

  localparam logic [2:0] BurstIncr   = 3'b001;
  localparam logic [2:0] BurstWrap4  = 3'b010;
  localparam logic [2:0] BurstIncr4  = 3'b011;
  localparam logic [2:0] BurstWrap8  = 3'b100;
  localparam logic [2:0] BurstIncr8  = 3'b101;
  localparam logic [2:0] BurstWrap16 = 3'b110;
  localparam logic [2:0] BurstIncr16 = 3'b111;

  logic [PORT_W-1:0]    addr_q, addr_d;
  logic                 no_port_q, no_port_d;
  logic                 burst_hold_q, burst_hold_d;
  logic [3:0]           beat_q, beat_d;
  logic [NUM_PORTS-1:0] eff_req;
  logic [PORT_W-1:0]    winner;
  logic                 seq_or_busy;

  function automatic logic [PORT_W-1:0] lowest_set(input logic [NUM_PORTS-1:0] vec);
    logic [PORT_W-1:0] idx;
    idx = '0;
    for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
      if (vec[i]) idx = PORT_W'(i);
    end
    return idx;
  endfunction

  assign seq_or_busy = (HTRANSM == TransSeq) || (HTRANSM == TransBusy);

  // The currently selected port keeps requesting while its own transfer is on the bus.
  always_comb begin
    eff_req = req_port;
    if (HSELM && (HTRANSM != TransIdle)) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if (addr_q == PORT_W'(i)) eff_req[i] = 1'b1;
      end
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  logic [PORT_W-1:0]    rr_last_q, rr_last_d;
  logic [NUM_PORTS-1:0] upper_mask;
  logic [NUM_PORTS-1:0] upper_req;

  // Ports above the last winner get first pick; fall back to the lowest index to wrap around.
  always_comb begin
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      upper_mask[i] = (PORT_W'(i) > rr_last_q);
    end
  end

  assign upper_req = eff_req & upper_mask;
  assign winner    = (|upper_req) ? lowest_set(upper_req) : lowest_set(eff_req);
`else
  assign winner = lowest_set(eff_req);
`endif

  // Next select, first matching rule wins.
  always_comb begin
    addr_d    = addr_q;
    no_port_d = no_port_q;
`ifdef ARB_ROUND_ROBIN_EN
    rr_last_d = rr_last_q;
`endif
    if (HMASTLOCKM) begin
      no_port_d = 1'b0;
    end else if ((beat_q != 4'd0) && seq_or_busy) begin
      // defined-length burst in flight
    end else if ((HBURSTM == BurstIncr) && seq_or_busy) begin
      // undefined-length burst continues
    end else if (|eff_req) begin
      addr_d    = winner;
      no_port_d = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_last_d = winner;
`endif
    end else if (HSELM) begin
      no_port_d = 1'b0;
    end else begin
      no_port_d = 1'b1;
    end
  end

  // Beat counter: remaining SEQ beats of a defined-length burst.
  always_comb begin
    beat_d = beat_q;
    unique case (HTRANSM)
      TransNonseq: begin
        case (HBURSTM)
          BurstWrap4,  BurstIncr4:  beat_d = 4'd3;
          BurstWrap8,  BurstIncr8:  beat_d = 4'd7;
          BurstWrap16, BurstIncr16: beat_d = 4'd15;
          default:                  beat_d = 4'd0;
        endcase
      end
      TransSeq:  beat_d = (beat_q != 4'd0) ? (beat_q - 4'd1) : 4'd0;
      TransBusy: beat_d = beat_q;
      TransIdle: beat_d = 4'd0;
    endcase
  end

  assign burst_hold_d = (beat_d != 4'd0);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      addr_q       <= '0;
      no_port_q    <= 1'b1;
      burst_hold_q <= 1'b0;
      beat_q       <= 4'd0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_last_q    <= PORT_W'(NUM_PORTS - 1);
`endif
    end else if (HREADYM) begin
      addr_q       <= addr_d;
      no_port_q    <= no_port_d;
      burst_hold_q <= burst_hold_d;
      beat_q       <= beat_d;
`ifdef ARB_ROUND_ROBIN_EN
      rr_last_q    <= rr_last_d;
`endif
    end
  end

  assign addr_in_port = addr_q;
  assign no_port      = no_port_q;
  assign burst_hold   = burst_hold_q;

endmodule
